// File: rtl/uart_pkg.sv
// Shared UART constants: byte width and default receive FIFO depth.
package uart_pkg;
    localparam int UART_BYTE_W          = 8;
    localparam int UART_FIFO_DEPTH_LOG2 = 4;
endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
// Write lands at the clock edge; the read port reflects it immediately after that edge.
module uart_fifo_mem #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_q [1<<AW];
    logic [DW-1:0] mem_d [1<<AW];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Contents are deliberately not reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/uart_rxfifo.sv
// UART receive FIFO, first-word-fall-through, with threshold irq and sticky overflow.
// 0-cycle fall-through; s_tready stays high outside reset, so bytes arriving while full are dropped.
module uart_rxfifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_BYTE_W-1:0] s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic                   rd_en,
    output logic [UART_BYTE_W-1:0] rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [DEPTH_LOG2:0]    count,
    input  logic [DEPTH_LOG2-1:0]  threshold,
    output logic                   irq,
    output logic                   overflow,
    input  logic                   ovf_clr
);
    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];

    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   push_req, push, pop, drop;
    logic [UART_BYTE_W-1:0] mem_rdata;

    assign s_tready = ~rst;
    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_CNT);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign irq      = (threshold != '0) && (count_q >= {1'b0, threshold});
    assign rd_data  = empty ? '0 : mem_rdata;

    // A same-cycle pop frees the slot, so a push into a full FIFO is only dropped without one.
    assign push_req = s_tvalid & s_tready;
    assign pop      = rd_en & ~empty;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (DEPTH_LOG2+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (DEPTH_LOG2+1)'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    uart_fifo_mem #(
        .AW (DEPTH_LOG2),
        .DW (UART_BYTE_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (s_tdata),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );
endmodule

// File: tb/tb_uart_rxfifo.sv
// Bench for uart_rxfifo: queue-based model checked every cycle, plus directed literal checks.
module tb_uart_rxfifo;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [DL:0]   count;
    logic [DL-1:0] threshold;
    logic          irq;
    logic          overflow;
    logic          ovf_clr;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    byte unsigned mq[$];
    bit           m_ovf;
    bit           m_drop;
    bit           m_pop;

    always #5 clk = ~clk;

    uart_rxfifo #(.DEPTH_LOG2(DL)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .threshold (threshold),
        .irq       (irq),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a byte queue of at most DEPTH entries and a sticky drop bit.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            m_pop  = rd_en && (mq.size() > 0);
            m_drop = s_tvalid && (mq.size() == DEPTH) && !m_pop;
            if (m_drop) begin
                m_ovf = 1'b1;
            end else begin
                if (ovf_clr) m_ovf = 1'b0;
                if (m_pop) void'(mq.pop_front());
                if (s_tvalid) mq.push_back(s_tdata);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_tready", 32'(s_tready), 32'(!rst));
            chk("m_count", 32'(count), 32'(mq.size()));
            chk("m_empty", 32'(empty), 32'(mq.size() == 0));
            chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
            chk("m_rd_data", 32'(rd_data), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
            chk("m_irq", 32'(irq), 32'((threshold != 0) && (mq.size() >= int'(threshold))));
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic cyc(input bit v, input logic [7:0] d, input bit r, input bit c);
        s_tvalid = v;
        s_tdata  = d;
        rd_en    = r;
        ovf_clr  = c;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tdata  = 8'h00;
        rd_en    = 1'b0;
        ovf_clr  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00; rd_en = 1'b0;
        ovf_clr = 1'b0; threshold = '0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk_en = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_tready", 32'(s_tready), 32'd0);
        rst = 1'b0;
        #1;
        chk("tready_run", 32'(s_tready), 32'd1);

        // Three bytes in, three out, strict order.
        cyc(1'b1, 8'h41, 1'b0, 1'b0);
        chk("fwft_first", 32'(rd_data), 32'h41);
        cyc(1'b1, 8'h42, 1'b0, 1'b0);
        cyc(1'b1, 8'h43, 1'b0, 1'b0);
        chk("abc_count", 32'(count), 32'd3);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("abc_pop1", 32'(rd_data), 32'h42);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("abc_pop2", 32'(rd_data), 32'h43);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("abc_empty", 32'(empty), 32'd1);
        chk("abc_cnt0", 32'(count), 32'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pop_empty_cnt", 32'(count), 32'd0);

        // Seventeen bytes with no pops: the last one is dropped.
        for (int i = 0; i < 17; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 15) chk("fill_full", 32'(full), 32'd1);
        end
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_drain", 32'(rd_data), 32'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("ovf_drained", 32'(empty), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr_alone", 32'(overflow), 32'd0);

        // Full plus simultaneous push/pop keeps count and does not overflow.
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("pp_count", 32'(count), 32'd16);
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_head", 32'(rd_data), 32'h11);
        for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pp_last", 32'(rd_data), 32'hAA);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Threshold interrupt.
        threshold = 4'd4;
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        chk("irq_3", 32'(irq), 32'd0);
        cyc(1'b1, 8'h63, 1'b0, 1'b0);
        chk("irq_4", 32'(irq), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("irq_pop", 32'(irq), 32'd0);
        for (int i = 0; i < 13; i++) cyc(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        chk("irq_full16", 32'(irq), 32'd1);
        threshold = 4'd0;
        #1;
        chk("irq_thr0", 32'(irq), 32'd0);

        // Clear racing a dropping push: set wins.
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("race_pre", 32'(overflow), 32'd1);
        cyc(1'b1, 8'hEF, 1'b0, 1'b1);
        chk("race_set_wins", 32'(overflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("race_clr", 32'(overflow), 32'd0);
        cyc(1'b1, 8'hF0, 1'b0, 1'b0);

        // Reset with 5 bytes held; a push in the reset cycle is lost.
        for (int i = 0; i < 11; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_cnt", 32'(count), 32'd5);
        rst = 1'b1;
        cyc(1'b1, 8'h99, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_rst_cnt", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);

        // Push with rd_en on an empty FIFO.
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        chk("emp_pp_cnt", 32'(count), 32'd1);
        chk("emp_pp_data", 32'(rd_data), 32'h55);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
